// File: rtl/alu_result_buffer.sv
// Capture FIFO for ALU results and flags, with a valid/ready drain port.
// Also keeps sticky CF/ZF summary flags and a saturating count of results dropped while full.
module alu_result_buffer #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1,
    parameter int DROP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_result,
    input  logic              in_cf,
    input  logic              in_sf,
    input  logic              in_zf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_result,
    output logic              out_cf,
    output logic              out_sf,
    output logic              out_zf,
    output logic [CNT_W-1:0]  count,
    output logic              sticky_cf,
    output logic              sticky_zf,
    input  logic              sticky_clr,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = WIDTH + 3;

    logic [DEPTH-1:0][ENT_W-1:0] mem_q;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        sticky_cf_q, sticky_cf_d, sticky_zf_q, sticky_zf_d;
    logic [DROP_W-1:0]           drop_q, drop_d;
    logic                        full, push, pop, drop;
    logic [ENT_W-1:0]            head;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign drop      = in_valid & !in_ready;

    // First-word fall-through: head entry is read straight from storage.
    assign head = mem_q[rd_ptr_q];
    assign {out_result, out_cf, out_sf, out_zf} = head;

    assign count     = count_q;
    assign sticky_cf = sticky_cf_q;
    assign sticky_zf = sticky_zf_q;
    assign drop_cnt  = drop_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
        // Clear takes effect first so a same-cycle push still contributes.
        sticky_cf_d = (sticky_clr ? 1'b0 : sticky_cf_q) | (push & in_cf);
        sticky_zf_d = (sticky_clr ? 1'b0 : sticky_zf_q) | (push & in_zf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            sticky_cf_q <= 1'b0;
            sticky_zf_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= {in_result, in_cf, in_sf, in_zf};
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            sticky_cf_q <= sticky_cf_d;
            sticky_zf_q <= sticky_zf_d;
            drop_q      <= drop_d;
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with hand-computed expectations.
module tb_alu_result_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_cf, in_sf, in_zf;
    logic [4:0] in_result, out_result;
    logic       out_valid, out_ready, out_cf, out_sf, out_zf;
    logic [2:0] count;
    logic       sticky_cf, sticky_zf, sticky_clr;
    logic [3:0] drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    alu_result_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_cf(in_cf), .in_sf(in_sf), .in_zf(in_zf),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cf(out_cf), .out_sf(out_sf), .out_zf(out_zf),
        .count(count), .sticky_cf(sticky_cf), .sticky_zf(sticky_zf),
        .sticky_clr(sticky_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] r, input logic cf, input logic sf, input logic zf);
        in_valid = v; in_result = r; in_cf = cf; in_sf = sf; in_zf = zf;
    endtask

    task automatic push(input logic [4:0] r, input logic cf, input logic sf, input logic zf);
        set_in(1'b1, r, cf, sf, zf);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        set_in(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #12 rst_n = 1'b1;
        tick();

        // 1: asynchronous reset mid-clock discards queued entry
        push(5'd7, 1'b1, 1'b0, 1'b1);
        chk("pre_rst_count", count, 1);
        chk("pre_rst_sticky_cf", sticky_cf, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_sticky", {sticky_cf, sticky_zf}, 0);
        chk("rst_out_result", out_result, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 2: single push of ADD 01101+00011 = 10000, SF=1
        push(5'b10000, 1'b0, 1'b1, 1'b0);
        chk("t2_valid", out_valid, 1);
        chk("t2_result", out_result, 5'b10000);
        chk("t2_sf", out_sf, 1);
        chk("t2_cf", out_cf, 0);
        chk("t2_count", count, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t2_count_pop", count, 0);
        chk("t2_valid_pop", out_valid, 0);

        // 3: fill, drop a fifth, drain in order
        for (int i = 1; i <= 4; i++) push(5'(i), 1'b0, 1'b0, 1'b0);
        chk("t3_count_full", count, 4);
        chk("t3_in_ready", in_ready, 0);
        push(5'd5, 1'b0, 1'b0, 1'b0);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_count_after_drop", count, 4);
        chk("t3_head_after_drop", out_result, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain", out_result, i);
            tick();
        end
        out_ready = 1'b0;
        chk("t3_empty", count, 0);

        // 4: simultaneous push/pop at count=2 across pointer wrap
        push(5'd10, 1'b0, 1'b0, 1'b0);
        push(5'd11, 1'b0, 1'b0, 1'b0);
        begin
            int hd = 10;
            for (int k = 0; k < 10; k++) begin
                set_in(1'b1, 5'(12 + k), 1'b0, 1'b0, 1'b0);
                out_ready = 1'b1;
                chk("t4_head", out_result, hd);
                tick();
                hd++;
                chk("t4_count", count, 2);
            end
            in_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                chk("t4_tail", out_result, hd);
                tick();
                hd++;
            end
            out_ready = 1'b0;
            chk("t4_empty", count, 0);
        end

        // 5: sticky flags
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        chk("t5_clr_alone", {sticky_cf, sticky_zf}, 0);
        push(5'd0, 1'b0, 1'b0, 1'b1);
        push(5'd1, 1'b1, 1'b0, 1'b0);
        chk("t5_zf_set", sticky_zf, 1);
        chk("t5_cf_set", sticky_cf, 1);
        sticky_clr = 1'b1;
        push(5'd2, 1'b0, 1'b0, 1'b0);
        chk("t5_clr_push0", {sticky_cf, sticky_zf}, 0);
        push(5'd0, 1'b0, 1'b0, 1'b1);
        sticky_clr = 1'b0;
        chk("t5_clr_push1_zf", sticky_zf, 1);
        chk("t5_clr_push1_cf", sticky_cf, 0);
        chk("t5_count", count, 4);

        // 6: drop counter saturation, and no pass-through when full
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(20 + i), 1'b0, 1'b0, 1'b0);
        set_in(1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) tick();
        chk("t6_drop_sat", drop_cnt, 15);
        chk("t6_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        chk("t6_no_passthru", count, 3);
        chk("t6_drop_hold", drop_cnt, 15);
        chk("t6_head", out_result, 21);
        in_valid = 1'b0; out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
